// File: rtl/drum_dot_accum_pkg.sv
// Shared types and helpers for the DRUM dot-product accumulator.
package drum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int PW_DEF = 16;
    localparam int AW_DEF = 24;
    localparam int XW     = 64;

    // Sign-extend a pw-bit ones'-complement product; oc adds the sign bit to reach two's complement.
    function automatic logic signed [XW-1:0] sext_corr(input logic [XW-1:0] prod,
                                                       input int          pw,
                                                       input logic        oc);
        logic [XW-1:0] hi_mask;
        logic [XW-1:0] one_v;
        logic [XW-1:0] ext;
        logic          sgn;
        one_v   = {{(XW-1){1'b0}}, 1'b1};
        hi_mask = {XW{1'b1}} << pw;
        sgn     = |(prod & (one_v << (pw - 1)));
        if (sgn) begin
            ext = prod | hi_mask;
        end else begin
            ext = prod & ~hi_mask;
        end
        return $signed(ext + {{(XW-1){1'b0}}, oc & sgn});
    endfunction

endpackage

// File: rtl/drum_dot_accum_if.sv
// Product-in / result-out handshake bundle of the dot-product accumulator.
interface drum_dot_accum_if #(
    parameter int PW    = 16,
    parameter int AW    = 24,
    parameter int LEN_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_prod;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_acc;
    logic             out_sat;
    logic [LEN_W-1:0] out_count;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_sat, out_count
    );
endinterface

// File: rtl/drum_dot_accum_sat_add.sv
// Signed saturating adder: AW-bit accumulator plus AW+1-bit term, clamped to AW bits.
module drum_sat_add #(
    parameter int AW = 24
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [AW:0]   b,
    output logic signed [AW-1:0] sum,
    output logic                 ovf
);
    logic signed [AW:0] full_s;

    // Wide sum, then clamp when the top two bits disagree.
    always_comb begin
        full_s = $signed({a[AW-1], a}) + b;
        ovf    = full_s[AW] ^ full_s[AW-1];
        if (ovf) begin
            if (full_s[AW]) begin
                sum = {1'b1, {(AW-1){1'b0}}};
            end else begin
                sum = {1'b0, {(AW-1){1'b1}}};
            end
        end else begin
            sum = full_s[AW-1:0];
        end
    end
endmodule

// File: rtl/drum_dot_accum.sv
// Accumulates LEN signed DRUM products into a saturating dot-product and holds it until consumed.
module drum_dot_accum import drum_pkg::*; #(
    parameter int PW      = PW_DEF,
    parameter int AW      = AW_DEF,
    parameter int LEN_W   = 8,
    parameter int OC_CORR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    drum_dot_accum_if.slave  io
);
    state_e                  state_r;
    logic signed [AW-1:0]    acc_r;
    logic [LEN_W-1:0]        cnt_r;
    logic [LEN_W-1:0]        len_q_r;
    logic                    sat_r;
    logic                    busy_r;
    logic                    out_valid_r;
    logic signed [AW-1:0]    out_acc_r;
    logic                    out_sat_r;
    logic [LEN_W-1:0]        out_count_r;
    logic signed [AW:0]      term_s;
    logic signed [AW-1:0]    sum_s;
    logic                    ovf_s;
    logic                    beat_s;

    assign term_s = (AW+1)'(sext_corr(XW'(io.in_prod), PW, 1'(OC_CORR)));
    assign beat_s = (state_r == ACC) && !abort && io.in_valid;

    drum_sat_add #(.AW(AW)) u_sat_add (
        .a   (acc_r),
        .b   (term_s),
        .sum (sum_s),
        .ovf (ovf_s)
    );

    // Control FSM, term counter, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            len_q_r     <= '0;
            sat_r       <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_acc_r   <= '0;
            out_sat_r   <= 1'b0;
            out_count_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r  <= '0;
                        cnt_r  <= '0;
                        sat_r  <= 1'b0;
                        busy_r <= 1'b1;
                        if (len != '0) begin
                            len_q_r <= len;
                            state_r <= ACC;
                        end else begin
                            // Empty dot-product goes straight to a zero result.
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                            out_acc_r   <= '0;
                            out_sat_r   <= 1'b0;
                            out_count_r <= '0;
                        end
                    end
                end
                ACC: begin
                    if (abort) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (beat_s) begin
                        acc_r <= sum_s;
                        sat_r <= sat_r | ovf_s;
                        cnt_r <= cnt_r + LEN_W'(1);
                        if (cnt_r == len_q_r - LEN_W'(1)) begin
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                            out_acc_r   <= sum_s;
                            out_sat_r   <= sat_r | ovf_s;
                            out_count_r <= cnt_r + LEN_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (abort || io.out_ready) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign io.in_ready  = (state_r == ACC) && !abort;
    assign io.out_valid = out_valid_r;
    assign io.out_acc   = out_acc_r;
    assign io.out_sat   = out_sat_r;
    assign io.out_count = out_count_r;
endmodule

// File: tb/tb_drum_dot_accum.sv
// Drives three accumulator configurations with one directed stream and checks them against a per-cycle model.
module tb_drum_dot_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        out_ready;
    logic        busy_a, busy_b, busy_c;
    bit          cmp_en = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    drum_dot_accum_if #(.PW(16), .AW(24), .LEN_W(8)) ifa ();
    drum_dot_accum_if #(.PW(16), .AW(24), .LEN_W(8)) ifb ();
    drum_dot_accum_if #(.PW(16), .AW(18), .LEN_W(8)) ifc ();

    assign ifa.in_valid = in_valid;  assign ifa.in_prod = in_prod;  assign ifa.out_ready = out_ready;
    assign ifb.in_valid = in_valid;  assign ifb.in_prod = in_prod;  assign ifb.out_ready = out_ready;
    assign ifc.in_valid = in_valid;  assign ifc.in_prod = in_prod;  assign ifc.out_ready = out_ready;

    drum_dot_accum #(.PW(16), .AW(24), .LEN_W(8), .OC_CORR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .busy(busy_a), .io(ifa));
    drum_dot_accum #(.PW(16), .AW(24), .LEN_W(8), .OC_CORR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .busy(busy_b), .io(ifb));
    drum_dot_accum #(.PW(16), .AW(18), .LEN_W(8), .OC_CORR(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .busy(busy_c), .io(ifc));

    // Transaction-level model: mode 0 idle, 1 collecting, 2 result held.
    typedef struct packed {
        int     mode;
        longint acc;
        int     cnt;
        int     tgt;
        bit     sat;
        longint racc;
        bit     rsat;
        int     rcnt;
        bit     ov;
    } mdl_t;

    mdl_t   mdl [3];
    int     cfg_aw [3] = '{24, 24, 18};
    bit     cfg_oc [3] = '{1'b1, 1'b0, 1'b1};

    function automatic mdl_t step(mdl_t s, int aw, bit oc);
        mdl_t   n = s;
        longint mx = (64'sd1 <<< (aw - 1)) - 64'sd1;
        longint mn = -mx - 64'sd1;
        longint t;
        if (!rst_n) begin
            n = '0;
        end else if (s.mode == 0) begin
            if (start) begin
                n.acc = 0; n.cnt = 0; n.sat = 1'b0;
                if (len != 8'd0) begin
                    n.tgt = int'(len); n.mode = 1;
                end else begin
                    n.mode = 2; n.racc = 0; n.rsat = 1'b0; n.rcnt = 0; n.ov = 1'b1;
                end
            end
        end else if (s.mode == 1) begin
            if (abort) begin
                n.mode = 0;
            end else if (in_valid) begin
                t = longint'($signed(in_prod)) + ((oc && in_prod[15]) ? 64'sd1 : 64'sd0);
                n.acc = s.acc + t;
                if (n.acc > mx) begin n.acc = mx; n.sat = 1'b1; end
                if (n.acc < mn) begin n.acc = mn; n.sat = 1'b1; end
                n.cnt = s.cnt + 1;
                if (n.cnt == s.tgt) begin
                    n.mode = 2; n.racc = n.acc; n.rsat = n.sat; n.rcnt = n.cnt; n.ov = 1'b1;
                end
            end
        end else begin
            if (abort || out_ready) begin
                n.mode = 0; n.ov = 1'b0;
            end
        end
        return n;
    endfunction

    // Advance the model on every active edge.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) mdl[k] <= step(mdl[k], cfg_aw[k], cfg_oc[k]);
    end

    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(int k, logic b, logic ir, logic ov, longint acc, logic sat, logic [7:0] cnt);
        chk($sformatf("busy[%0d]", k),      longint'(b),   longint'(mdl[k].mode != 0));
        chk($sformatf("in_ready[%0d]", k),  longint'(ir),  longint'(mdl[k].mode == 1 && !abort));
        chk($sformatf("out_valid[%0d]", k), longint'(ov),  longint'(mdl[k].ov));
        chk($sformatf("out_acc[%0d]", k),   acc,           mdl[k].racc);
        chk($sformatf("out_sat[%0d]", k),   longint'(sat), longint'(mdl[k].rsat));
        chk($sformatf("out_count[%0d]", k), longint'(cnt), longint'(mdl[k].rcnt));
    endtask

    // Compare every DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, busy_a, ifa.in_ready, ifa.out_valid, longint'($signed(ifa.out_acc)), ifa.out_sat, ifa.out_count);
            cmp_inst(1, busy_b, ifb.in_ready, ifb.out_valid, longint'($signed(ifb.out_acc)), ifb.out_sat, ifb.out_count);
            cmp_inst(2, busy_c, ifc.in_ready, ifc.out_valid, longint'($signed(ifc.out_acc)), ifc.out_sat, ifc.out_count);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(logic [7:0] l);
        start = 1'b1; len = l;
        cyc();
        start = 1'b0;
    endtask

    task automatic beat(logic [15:0] p);
        in_valid = 1'b1; in_prod = p;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        int got;
        bit was;
        rst_n = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
        in_valid = 1'b0; in_prod = 16'h0000; out_ready = 1'b0;
        repeat (2) cyc();
        cmp_en = 1'b1;
        cyc();
        chk("reset_busy", longint'(busy_a), 0);
        chk("reset_out_valid", longint'(ifa.out_valid), 0);
        chk("reset_out_acc", longint'(ifa.out_acc), 0);
        rst_n = 1'b1;
        cyc();

        // Mixed-sign products, ones'-comp correction on and off.
        start_run(8'd3);
        beat(16'h0005); beat(16'h0003); beat(16'hFFF9);
        chk("t1_valid_next_cycle", longint'(ifa.out_valid), 1);
        chk("t1_acc_oc1", longint'($signed(ifa.out_acc)), 2);
        chk("t1_acc_oc0", longint'($signed(ifb.out_acc)), 1);
        chk("t1_count", longint'(ifa.out_count), 3);
        chk("t1_sat", longint'(ifa.out_sat), 0);
        chk("t1_model_pin", mdl[0].racc, 2);
        release_out();

        // Positive then negative saturation in the 18-bit accumulator.
        start_run(8'd5);
        repeat (5) beat(16'h7FFF);
        chk("t3_pos_acc18", longint'(ifc.out_acc), 64'h1FFFF);
        chk("t3_pos_sat18", longint'(ifc.out_sat), 1);
        chk("t3_pos_acc24", longint'($signed(ifa.out_acc)), 163835);
        chk("t3_pos_sat24", longint'(ifa.out_sat), 0);
        release_out();
        start_run(8'd5);
        repeat (5) beat(16'h8000);
        chk("t3_neg_acc18", longint'(ifc.out_acc), 64'h20000);
        chk("t3_neg_sat18", longint'(ifc.out_sat), 1);
        chk("t3_neg_acc24_oc0", longint'($signed(ifb.out_acc)), -163840);
        release_out();

        // Empty dot-product; products offered during HOLD must be ignored.
        start_run(8'd0);
        chk("t4_valid", longint'(ifa.out_valid), 1);
        chk("t4_acc", longint'(ifa.out_acc), 0);
        in_valid = 1'b1; in_prod = 16'h0055;
        chk("t4_in_ready", longint'(ifa.in_ready), 0);
        repeat (2) cyc();
        in_valid = 1'b0;
        chk("t4_count", longint'(ifa.out_count), 0);
        release_out();

        // Random in_valid gaps, then 10 cycles of output backpressure.
        start_run(8'd4);
        got = 0;
        for (int i = 0; i < 200 && got < 4; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_prod  = 16'(16'h0100 * (got + 1));
            was = in_valid && ifa.in_ready;
            cyc();
            if (was) got++;
        end
        in_valid = 1'b0;
        chk("t5_beats", got, 4);
        repeat (10) cyc();
        chk("t5_held_valid", longint'(ifa.out_valid), 1);
        chk("t5_held_acc", longint'($signed(ifa.out_acc)), 2560);
        start = 1'b1; out_ready = 1'b1;
        cyc();
        start = 1'b0; out_ready = 1'b0;
        chk("t5_idle_after_ready", longint'(busy_a), 0);
        cyc();
        chk("t5_start_ignored", longint'(busy_a), 0);

        // Abort mid-run with a coincident beat, then a clean one-term run.
        start_run(8'd4);
        beat(16'h0001); beat(16'h0002);
        abort = 1'b1; in_valid = 1'b1; in_prod = 16'h0005;
        cyc();
        abort = 1'b0; in_valid = 1'b0;
        chk("t6_abort_busy", longint'(busy_a), 0);
        chk("t6_abort_in_ready", longint'(ifa.in_ready), 0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_valid", longint'(ifa.out_valid), 0);
            cyc();
        end
        chk("t6_old_result_kept", longint'($signed(ifa.out_acc)), 2560);
        abort = 1'b1;
        start_run(8'd1);
        abort = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !ifa.in_ready; i++) cyc();
        chk("t6_in_ready_timeout", longint'(ifa.in_ready), 1);
        beat(16'h0007);
        chk("t6_acc", longint'($signed(ifa.out_acc)), 7);
        chk("t6_acc18", longint'($signed(ifc.out_acc)), 7);
        chk("t6_sat", longint'(ifa.out_sat), 0);
        chk("t6_count", longint'(ifa.out_count), 1);
        release_out();
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
